// File: rtl/sensor_alarm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sensor_alarm_pkg
// Brief    : Shared types and helpers for the sensor-to-buzzer alarm block.
// Revision : 1.0 - initial release
// ============================================================================
package sensor_alarm_pkg;

  // Controller phases: waiting, qualifying a candidate, sounding, suppressing.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUAL    = 2'd1,
    ALARM   = 2'd2,
    HOLDOFF = 2'd3
  } state_e;

  // Channel index width; a single channel still needs one bit.
  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sensor_prio_enc.sv
`default_nettype none
// ============================================================================
// Module   : sensor_prio_enc
// Brief    : Lowest-index-wins priority encoder over the sensor inputs.
// Revision : 1.0 - initial release
// ============================================================================
module sensor_prio_enc
  import sensor_alarm_pkg::*;
#(
  parameter int N_CH = 3,
  parameter int CH_W = ch_w(N_CH)
) (
  input  logic [N_CH-1:0] req_i,
  output logic            valid_o,
  output logic [CH_W-1:0] idx_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = CH_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sensor_alarm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sensor_alarm_ctrl
// Brief    : Debounced priority alarm controller: qualify, sound, hold off.
// Revision : 1.0 - initial release
// ============================================================================
module sensor_alarm_ctrl
  import sensor_alarm_pkg::*;
#(
  parameter int N_CH        = 3,
  parameter int DEB_LEN     = 8,
  parameter int ALARM_LEN   = 32,
  parameter int HOLDOFF_LEN = 16,
  localparam int CH_W       = ch_w(N_CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic [N_CH-1:0] sensor,
  input  logic            ack,
  output logic [N_CH-1:0] buzzer,
  output logic [CH_W-1:0] alarm_ch,
  output logic            busy
);

  localparam int DEB_W   = $clog2(DEB_LEN + 1);
  localparam int DUR_MAX = (ALARM_LEN > HOLDOFF_LEN) ? ALARM_LEN : HOLDOFF_LEN;
  localparam int DUR_W   = $clog2(DUR_MAX + 1);

  localparam logic [DEB_W-1:0] DEB_ONE    = DEB_W'(1);
  localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEB_LEN);
  localparam logic [DUR_W-1:0] DUR_ONE    = DUR_W'(1);
  localparam logic [DUR_W-1:0] ALARM_LAST = DUR_W'(ALARM_LEN);
  localparam logic [DUR_W-1:0] HOLD_LAST  = DUR_W'(HOLDOFF_LEN);
  localparam logic [N_CH-1:0]  CH_ONE     = N_CH'(1);

  state_e            state_q;
  logic [DEB_W-1:0]  deb_cnt_q;
  logic [DUR_W-1:0]  dur_cnt_q;
  logic [CH_W-1:0]   cand_q;
  logic [N_CH-1:0]   buzzer_q;
  logic [CH_W-1:0]   alarm_ch_q;
  logic              busy_q;

  logic              w_win_valid;
  logic [CH_W-1:0]   w_win_idx;
  logic [DEB_W-1:0]  w_deb_next;

  sensor_prio_enc #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_prio_enc (
    .req_i   (sensor),
    .valid_o (w_win_valid),
    .idx_o   (w_win_idx)
  );

  // Debounce counter never exceeds DEB_LEN, so the increment cannot wrap.
  assign w_deb_next = deb_cnt_q + DEB_ONE;

  // Alarm FSM with counters and registered outputs; everything freezes while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      deb_cnt_q  <= '0;
      dur_cnt_q  <= '0;
      cand_q     <= '0;
      buzzer_q   <= '0;
      alarm_ch_q <= '0;
      busy_q     <= 1'b0;
    end else if (ena) begin
      case (state_q)
        IDLE: begin
          if (w_win_valid) begin
            cand_q     <= w_win_idx;
            alarm_ch_q <= w_win_idx;
            deb_cnt_q  <= DEB_ONE;
            if (DEB_LEN == 1) begin
              // A single qualifying sample is enough: fire on this edge.
              state_q   <= ALARM;
              buzzer_q  <= CH_ONE << w_win_idx;
              dur_cnt_q <= DUR_ONE;
              busy_q    <= 1'b1;
            end else begin
              state_q <= QUAL;
            end
          end
        end

        QUAL: begin
          if (!w_win_valid) begin
            deb_cnt_q <= '0;
            state_q   <= IDLE;
          end else if (w_win_idx != cand_q) begin
            // A different channel took priority: restart qualification on it.
            cand_q     <= w_win_idx;
            alarm_ch_q <= w_win_idx;
            deb_cnt_q  <= DEB_ONE;
          end else begin
            deb_cnt_q <= w_deb_next;
            if (w_deb_next == DEB_LAST) begin
              state_q   <= ALARM;
              buzzer_q  <= CH_ONE << cand_q;
              alarm_ch_q <= cand_q;
              dur_cnt_q <= DUR_ONE;
              busy_q    <= 1'b1;
            end
          end
        end

        ALARM: begin
          if (ack || (dur_cnt_q == ALARM_LAST)) begin
            buzzer_q  <= '0;
            deb_cnt_q <= '0;
            if (HOLDOFF_LEN == 0) begin
              state_q   <= IDLE;
              dur_cnt_q <= '0;
              busy_q    <= 1'b0;
            end else begin
              state_q   <= HOLDOFF;
              dur_cnt_q <= DUR_ONE;
            end
          end else begin
            dur_cnt_q <= dur_cnt_q + DUR_ONE;
          end
        end

        HOLDOFF: begin
          if (dur_cnt_q == HOLD_LAST) begin
            state_q   <= IDLE;
            dur_cnt_q <= '0;
            busy_q    <= 1'b0;
          end else begin
            dur_cnt_q <= dur_cnt_q + DUR_ONE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign buzzer   = buzzer_q;
  assign alarm_ch = alarm_ch_q;
  assign busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_sensor_alarm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sensor_alarm_ctrl
// Brief    : Self-checking bench for sensor_alarm_ctrl (two configurations).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sensor_alarm_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [2:0] sen_a;
  logic       ack_a;
  logic [7:0] sen_b;
  logic       ack_b;

  logic [2:0] buz_a;
  logic [1:0] ch_a;
  logic       busy_a;
  logic [7:0] buz_b;
  logic [2:0] ch_b;
  logic       busy_b;

  int errors = 0;
  int checks = 0;
  int cnt;

  // Behavioural model: a qualifying streak, then countdown timers for the
  // sounding and suppression windows.
  typedef struct {
    int cand;
    int streak;
    int alarm_left;
    int hold_left;
    int buz_ch;
    int last_ch;
  } mdl_t;

  mdl_t ma, mb;

  always #5 clk = ~clk;

  sensor_alarm_ctrl dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .sensor   (sen_a),
    .ack      (ack_a),
    .buzzer   (buz_a),
    .alarm_ch (ch_a),
    .busy     (busy_a)
  );

  sensor_alarm_ctrl #(
    .N_CH        (8),
    .DEB_LEN     (1),
    .ALARM_LEN   (32),
    .HOLDOFF_LEN (0)
  ) dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .sensor   (sen_b),
    .ack      (ack_b),
    .buzzer   (buz_b),
    .alarm_ch (ch_b),
    .busy     (busy_b)
  );

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.cand = -1; m.streak = 0; m.alarm_left = 0;
    m.hold_left = 0; m.buz_ch = 0; m.last_ch = 0;
    return m;
  endfunction

  function automatic int lowest(input logic [15:0] s);
    for (int i = 0; i < 16; i++) if (s[i]) return i;
    return -1;
  endfunction

  function automatic mdl_t mdl_next(input mdl_t m, input int deb, input int alen,
                                    input int hlen, input logic [15:0] s,
                                    input logic a, input logic en);
    mdl_t n;
    int   w;
    n = m;
    if (!en) return n;
    if (n.alarm_left > 0) begin
      if (a || n.alarm_left == 1) begin
        n.alarm_left = 0;
        n.hold_left  = hlen;
      end else begin
        n.alarm_left--;
      end
      return n;
    end
    if (n.hold_left > 0) begin
      n.hold_left--;
      return n;
    end
    w = lowest(s);
    if (w < 0) begin
      n.streak = 0;
      return n;
    end
    if (n.streak > 0 && w == n.cand) n.streak++;
    else begin
      n.cand   = w;
      n.streak = 1;
    end
    n.last_ch = w;
    if (n.streak == deb) begin
      n.alarm_left = alen;
      n.buz_ch     = w;
      n.streak     = 0;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("buzzer_a", {13'd0, buz_a}, (ma.alarm_left > 0) ? 16'(1 << ma.buz_ch) : 16'd0);
    chk("alarm_ch_a", {14'd0, ch_a}, 16'(ma.last_ch));
    chk("busy_a", {15'd0, busy_a}, {15'd0, (ma.alarm_left > 0 || ma.hold_left > 0)});
    chk("buzzer_b", {8'd0, buz_b}, (mb.alarm_left > 0) ? 16'(1 << mb.buz_ch) : 16'd0);
    chk("alarm_ch_b", {13'd0, ch_b}, 16'(mb.last_ch));
    chk("busy_b", {15'd0, busy_b}, {15'd0, (mb.alarm_left > 0 || mb.hold_left > 0)});
  endtask

  task automatic step();
    @(posedge clk);
    ma = mdl_next(ma, 8, 32, 16, {13'd0, sen_a}, ack_a, ena);
    mb = mdl_next(mb, 1, 32, 0, {8'd0, sen_b}, ack_b, ena);
    #1;
    compare_all();
  endtask

  // Asynchronous reset pulse, checked before any clock edge can intervene.
  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    ma = mdl_reset();
    mb = mdl_reset();
    compare_all();
    chk("rst_zero", {buz_b, 2'd0, buz_a, busy_a, busy_b}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1;
    sen_a = '0; ack_a = 1'b0; sen_b = '0; ack_b = 1'b0;
    ma = mdl_reset(); mb = mdl_reset();
    #2;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Held sensor on channel 1: fire after 8 edges, 32 on, 16 hold-off.
    sen_a = 3'b010;
    repeat (7) step();
    chk("t1_before_fire", {13'd0, buz_a}, 16'd0);
    step();
    chk("t1_fire", {13'd0, buz_a}, 16'b010);
    chk("t1_ch", {14'd0, ch_a}, 16'd1);
    cnt = 1;
    for (int i = 0; i < 100 && buz_a != 0; i++) begin
      step();
      if (buz_a != 0) cnt++;
    end
    chk("t1_alarm_len", 16'(cnt), 16'd32);
    sen_a = 3'b000;
    cnt = 0;
    for (int i = 0; i < 100 && busy_a; i++) begin
      step();
      cnt++;
    end
    chk("t1_holdoff_len", 16'(cnt), 16'd16);

    // Higher-priority channel takes over mid-qualification.
    sen_a = 3'b100;
    repeat (5) step();
    chk("t2_ch_cand2", {14'd0, ch_a}, 16'd2);
    sen_a = 3'b001;
    repeat (7) step();
    chk("t2_no_early", {13'd0, buz_a}, 16'd0);
    chk("t2_ch_cand0", {14'd0, ch_a}, 16'd0);
    step();
    chk("t2_fire", {13'd0, buz_a}, 16'b001);
    sen_a = 3'b000;
    for (int i = 0; i < 100 && busy_a; i++) step();
    chk("t2_idle", {15'd0, busy_a}, 16'd0);

    // Acknowledge on the 10th alarm cycle.
    sen_a = 3'b010;
    for (int i = 0; i < 20 && buz_a == 0; i++) step();
    sen_a = 3'b000;
    repeat (9) step();
    ack_a = 1'b1;
    step();
    ack_a = 1'b0;
    chk("t3_ack_drop", {13'd0, buz_a}, 16'd0);
    chk("t3_busy", {15'd0, busy_a}, 16'd1);
    cnt = 0;
    for (int i = 0; i < 100 && busy_a; i++) begin
      step();
      cnt++;
    end
    chk("t3_holdoff_len", 16'(cnt), 16'd16);

    // Drop at deb_cnt=7, then a full fresh qualification.
    sen_a = 3'b010;
    repeat (7) step();
    chk("t4_pre_drop", {13'd0, buz_a}, 16'd0);
    sen_a = 3'b000;
    step();
    sen_a = 3'b010;
    repeat (7) step();
    chk("t4_no_early", {13'd0, buz_a}, 16'd0);
    step();
    chk("t4_fire", {13'd0, buz_a}, 16'b010);

    // ena toggling at 50% doubles the alarm length in clocks.
    sen_a = 3'b000;
    cnt = 1;
    ena = 1'b0;
    for (int i = 0; i < 300 && buz_a != 0; i++) begin
      step();
      if (buz_a != 0) cnt++;
      ena = ~ena;
    end
    chk("t5_ena_alarm_len", 16'(cnt), 16'd64);
    ena = 1'b1;
    repeat (5) step();
    chk("t5_mid_holdoff", {15'd0, busy_a}, 16'd1);
    async_reset();

    // Reset in the middle of an alarm.
    sen_a = 3'b001;
    repeat (8) step();
    chk("t5b_fire", {13'd0, buz_a}, 16'b001);
    step();
    async_reset();
    sen_a = 3'b000;

    // Wide, single-sample configuration with no hold-off.
    sen_b = 8'h80;
    step();
    chk("t6_fire", {8'd0, buz_b}, 16'h80);
    chk("t6_ch", {13'd0, ch_b}, 16'd7);
    cnt = 1;
    for (int i = 0; i < 100 && buz_b != 0; i++) begin
      step();
      if (buz_b != 0) cnt++;
    end
    chk("t6_alarm_len", 16'(cnt), 16'd32);
    chk("t6_busy_off", {15'd0, busy_b}, 16'd0);
    step();
    chk("t6_retrigger", {8'd0, buz_b}, 16'h80);
    sen_b = 8'h00;
    repeat (40) step();

    // Randomised traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) sen_a = 3'($urandom);
      if ($urandom_range(0, 15) == 0) sen_b = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
      ack_a = ($urandom_range(0, 30) == 0);
      ack_b = ($urandom_range(0, 30) == 0);
      ena   = ($urandom_range(0, 9) != 0);
      step();
      if ($urandom_range(0, 499) == 0) async_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sensor_alarm_ctrl.md
# sensor_alarm_ctrl

Parametrised multi-channel sensor-to-buzzer alarm controller. Each sensor input must be the highest-priority asserted channel for a programmable number of consecutive cycles before its buzzer fires. The buzzer then sounds for a fixed duration, can be cut short by an acknowledge, and is followed by a hold-off window that suppresses retriggering. The block sits between the raw sensor pins and the buzzer output pins of the top-level tile.

## Interface
Parameters:
- N_CH, 3: number of sensor/buzzer channels; legal range 1..16.
- DEB_LEN, 8: consecutive qualifying cycles required to fire; must be ≥1.
- ALARM_LEN, 32: buzzer on-time in enabled cycles; must be ≥1.
- HOLDOFF_LEN, 16: post-alarm suppression in enabled cycles; 0 means none.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset: asynchronous, active-low.
- ena  in  1  clock enable; when low, all state and outputs hold.
- sensor  in  N_CH  level sensor inputs, synchronous to clk; bit 0 has highest priority.
- ack  in  1  alarm acknowledge; sampled only in ALARM.
- buzzer  out  N_CH  one-hot buzzer drive while in ALARM, otherwise all zero.
- alarm_ch  out  CH_W  index of the firing or qualifying channel. CH_W = max(1, $clog2(N_CH)).
- busy  out  1  high in ALARM or HOLDOFF.

## Operation
- Reset, asynchronous: state=IDLE, deb_cnt=0, dur_cnt=0, cand=0, buzzer=0, alarm_ch=0, busy=0.
- Winner: the lowest-index asserted sensor bit. "None" when sensor==0.
- All transitions below occur only on edges where ena=1.
- IDLE:
  - Winner exists: cand←winner, deb_cnt←1.
  - If DEB_LEN==1, go directly to ALARM. Otherwise go to QUAL.
- QUAL:
  - Winner==cand: deb_cnt increments. When deb_cnt reaches DEB_LEN on this edge, go to ALARM.
  - Winner≠cand and not none: cand←winner, deb_cnt←1, stay in QUAL. This restarts qualification.
  - None: deb_cnt←0, go to IDLE.
- ALARM:
  - On entry: buzzer←one-hot(cand), alarm_ch←cand, dur_cnt←1.
  - Each subsequent edge: dur_cnt increments.
  - When dur_cnt==ALARM_LEN, or ack=1: buzzer←0, go to HOLDOFF. If HOLDOFF_LEN==0, go to IDLE instead.
  - Sensor changes are ignored in ALARM.
- HOLDOFF: count HOLDOFF_LEN cycles with sensors ignored and deb_cnt held at 0, then go to IDLE.
- Retrigger: a sensor still asserted after HOLDOFF needs a fresh DEB_LEN cycles to fire again.
- alarm_ch tracks cand in QUAL and ALARM. It holds its last value in IDLE and HOLDOFF.
- Counter widths: deb_cnt is $clog2(DEB_LEN+1) bits, dur_cnt is $clog2(max(ALARM_LEN,HOLDOFF_LEN)+1) bits. Neither counter ever wraps.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Fire latency: sensor stable from before edge k. Buzzer is high after edge k+DEB_LEN−1, i.e. DEB_LEN sampling edges.
- Buzzer stays high for exactly ALARM_LEN enabled cycles when not acknowledged.
- ack sampled high at edge j in ALARM: buzzer is low after edge j.
  - ack in the same cycle as expiry behaves as a single exit.
  - ack outside ALARM has no effect.
- busy rises on the same edge as buzzer. It falls HOLDOFF_LEN enabled edges after buzzer falls.
- ena low mid-count: counts freeze and resume without loss. Each ena-low cycle extends the alarm by one clock.
- rst_n asserted mid-ALARM: buzzer drops immediately (asynchronous). After release, the block restarts in IDLE.

## Structure
- Package sensor_alarm_pkg holds:
  - the state enum: IDLE, QUAL, ALARM, HOLDOFF, 2-bit encoding.
  - the CH_W helper function.
- Sub-module sensor_prio_enc is parametrised by N_CH. It outputs valid plus a CH_W index of the lowest set bit.
- The remaining logic is the FSM, two counters and the output registers.

## Test plan
- Default params, sensor=3'b010 held: buzzer=3'b010 after the 8th edge, stays high for 32 cycles, busy falls 16 cycles later, alarm_ch=1.
- sensor=3'b100 for 5 cycles, then 3'b001: cand switches to 0 and deb_cnt restarts; buzzer=3'b001 only after 8 cycles of 3'b001.
- ack pulsed on the 10th ALARM cycle: buzzer=0 on the next edge; busy is high for exactly 16 more cycles.
- Sensor dropped to 0 at deb_cnt=7: back to IDLE, no buzzer; reasserting needs a full 8 cycles.
- ena toggled 50% during ALARM: buzzer high for 64 clocks. rst_n pulsed mid-HOLDOFF: all outputs 0 immediately.
- N_CH=8, DEB_LEN=1, HOLDOFF_LEN=0, sensor=8'h80: buzzer=8'h80 after the first edge; retrigger 1 cycle after expiry.
